// File: rtl/satatrn_rxfisroute.sv
// Receive FIS router: DATA FIS words go out through a one-stage backpressured register; all other FIS types
// go into a frame-committed register FIFO. Optional counters are enabled by defining SATA_RXROUTE_STATS_EN.
module satatrn_rxfisroute #(
    parameter int         LGFIFO    = 4,
    parameter int         MAXREGLEN = 7,
    parameter logic [7:0] FIS_DATA  = 8'h46
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_link_err,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_data,
    input  logic        i_last,
    output logic        o_reg_valid,
    input  logic        i_reg_ready,
    output logic [31:0] o_reg_data,
    output logic        o_reg_last,
    output logic        o_data_valid,
    input  logic        i_data_ready,
    output logic [31:0] o_data_data,
    output logic        o_data_last,
`ifdef SATA_RXROUTE_STATS_EN
    output logic [15:0] o_drop_count,
    output logic [15:0] o_frame_count,
`endif
    output logic        o_drop
);
    localparam int DEPTH = 1 << LGFIFO;
    localparam int CW    = $clog2(MAXREGLEN + 1);
    localparam logic [LGFIFO:0] FULLV = {1'b1, {LGFIFO{1'b0}}};

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REG     = 2'd1;
    localparam logic [1:0] DATA    = 2'd2;
    localparam logic [1:0] DISCARD = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [LGFIFO:0]   wr_spec_q, wr_spec_d, wr_commit_q, wr_commit_d, rd_ptr_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [32:0]       mem_q [DEPTH];
    logic [31:0]       dat_q;
    logic              dvld_q, dlast_q, drop_q, drop_d;
    logic              wr_en, dload, commit, is_data, dok, full, acc, rd_en;

    assign is_data = (i_data[31:24] == FIS_DATA);
    assign dok     = !dvld_q || i_data_ready;
    assign full    = ((wr_spec_q - rd_ptr_q) == FULLV);
    assign acc     = i_valid && o_ready;

    // In IDLE only a DATA header needs room in the output stage; register frames never stall.
    always_comb begin
        o_ready = 1'b1;
        case (state_q)
            IDLE:    o_ready = is_data ? dok : 1'b1;
            DATA:    o_ready = dok;
            default: o_ready = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wr_spec_d   = wr_spec_q;
        wr_commit_d = wr_commit_q;
        cnt_d       = cnt_q;
        drop_d      = 1'b0;
        wr_en       = 1'b0;
        dload       = 1'b0;
        commit      = 1'b0;
        if (i_link_err) begin
            // Abort: any word presented this cycle belongs to the broken frame and is dropped.
            state_d   = IDLE;
            wr_spec_d = wr_commit_q;
            drop_d    = (state_q == REG);
        end else begin
            case (state_q)
                IDLE: if (acc) begin
                    if (is_data) begin
                        dload   = 1'b1;
                        state_d = i_last ? IDLE : DATA;
                    end else if (full) begin
                        drop_d  = 1'b1;
                        state_d = i_last ? IDLE : DISCARD;
                    end else begin
                        wr_en     = 1'b1;
                        wr_spec_d = wr_spec_q + 1'b1;
                        cnt_d     = CW'(1);
                        if (i_last) begin
                            wr_commit_d = wr_spec_q + 1'b1;
                            commit      = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            state_d = REG;
                        end
                    end
                end
                REG: if (acc) begin
                    if (full || int'(cnt_q) >= MAXREGLEN) begin
                        wr_spec_d = wr_commit_q;
                        drop_d    = 1'b1;
                        state_d   = i_last ? IDLE : DISCARD;
                    end else begin
                        wr_en     = 1'b1;
                        wr_spec_d = wr_spec_q + 1'b1;
                        cnt_d     = cnt_q + 1'b1;
                        if (i_last) begin
                            wr_commit_d = wr_spec_q + 1'b1;
                            commit      = 1'b1;
                            state_d     = IDLE;
                        end
                    end
                end
                DATA: if (acc) begin
                    dload = 1'b1;
                    if (i_last) state_d = IDLE;
                end
                default: if (acc && i_last) state_d = IDLE;
            endcase
        end
    end

    assign rd_en = o_reg_valid && i_reg_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            wr_spec_q   <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_spec_q   <= wr_spec_d;
            wr_commit_q <= wr_commit_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem_q[wr_spec_q[LGFIFO-1:0]] <= {i_last, i_data};
    end

    // A stalled word is never cleared without a handshake, even across a link error.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            dvld_q  <= 1'b0;
            dat_q   <= '0;
            dlast_q <= 1'b0;
        end else if (dload) begin
            dvld_q  <= 1'b1;
            dat_q   <= i_data;
            dlast_q <= i_last;
        end else if (i_data_ready) begin
            dvld_q  <= 1'b0;
        end
    end

    assign o_reg_valid  = (rd_ptr_q != wr_commit_q);
    assign o_reg_data   = mem_q[rd_ptr_q[LGFIFO-1:0]][31:0];
    assign o_reg_last   = mem_q[rd_ptr_q[LGFIFO-1:0]][32];
    assign o_data_valid = dvld_q;
    assign o_data_data  = dat_q;
    assign o_data_last  = dlast_q;
    assign o_drop       = drop_q;

`ifdef SATA_RXROUTE_STATS_EN
    logic [15:0] drop_cnt_q, frame_cnt_q;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            drop_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            if (drop_q && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 1'b1;
            if (commit && frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end
    assign o_drop_count  = drop_cnt_q;
    assign o_frame_count = frame_cnt_q;
`endif
endmodule

// File: tb/tb_satatrn_rxfisroute.sv
// Scoreboard bench for satatrn_rxfisroute: expected words are queued at drive time and checked as they leave.
module tb_satatrn_rxfisroute;
    logic        clk = 1'b0;
    logic        rst, lerr, vld, rdy, last, rvld, rrdy, rlast, dvld, drdy, dlast, drop;
    logic [31:0] din, rdata, ddata;
`ifdef SATA_RXROUTE_STATS_EN
    logic [15:0] dcnt, fcnt;
`endif

    satatrn_rxfisroute dut (
        .i_clk(clk), .i_reset(rst), .i_link_err(lerr), .i_valid(vld), .o_ready(rdy),
        .i_data(din), .i_last(last), .o_reg_valid(rvld), .i_reg_ready(rrdy),
        .o_reg_data(rdata), .o_reg_last(rlast), .o_data_valid(dvld), .i_data_ready(drdy),
        .o_data_data(ddata), .o_data_last(dlast),
`ifdef SATA_RXROUTE_STATS_EN
        .o_drop_count(dcnt), .o_frame_count(fcnt),
`endif
        .o_drop(drop)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int drops_seen = 0, nread = 0, nlast = 0;
    logic [32:0] reg_q[$], dat_q[$];
    bit          chk_rdy = 0, prev_stall = 0;
    logic [32:0] prev_word;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitors sample at negedge, where handshakes for the next posedge are stable.
    always @(negedge clk) begin
        logic [32:0] e;
        if (drop) drops_seen++;
        if (rvld && rrdy) begin
            if (reg_q.size() == 0) chk("reg_spurious", 64'(rvld), 64'd0);
            else begin
                e = reg_q.pop_front();
                chk("reg_word", {31'd0, rlast, rdata}, {31'd0, e});
                nread++;
                if (rlast) nlast++;
            end
        end
        if (prev_stall) begin
            chk("data_hold_vld", 64'(dvld), 64'd1);
            chk("data_hold", {31'd0, dlast, ddata}, {31'd0, prev_word});
        end
        prev_stall = dvld && !drdy && !rst;
        prev_word  = {dlast, ddata};
        if (chk_rdy && vld) chk("data_ready", 64'(rdy), 64'(!(dvld && !drdy)));
        if (dvld && drdy) begin
            if (dat_q.size() == 0) chk("data_spurious", 64'(dvld), 64'd0);
            else begin
                e = dat_q.pop_front();
                chk("data_word", {31'd0, dlast, ddata}, {31'd0, e});
            end
        end
    end

    task automatic send(input logic [31:0] d, input bit l, input bit err);
        bit ok = 0;
        vld = 1; din = d; last = l; lerr = err;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = rdy;
            @(posedge clk); #1;
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        vld = 0; last = 0; lerr = 0;
    endtask

    // mode 1: register output must stay idle before commit; mode 2: drop pulse right after word 8
    task automatic frame(input logic [7:0] typ, input int n, input bit keep, input int mode);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = (i == 0) ? {typ, 24'($urandom)} : $urandom;
            if (i == 0 && typ != 8'h46 && w[31:24] == 8'h46) w[31:24] = 8'h34;
            if (keep) begin
                if (typ == 8'h46) dat_q.push_back({i == n - 1, w});
                else              reg_q.push_back({i == n - 1, w});
            end
            send(w, i == n - 1, 1'b0);
            if (mode == 1 && i < n - 1) chk("early_reg_vld", 64'(rvld), 64'd0);
            if (mode == 2 && i == 7)    chk("drop_at_w8", 64'(drop), 64'd1);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (reg_q.size() != 0 || dat_q.size() != 0); k++) begin
            @(posedge clk); #2;
        end
        chk("reg_left", 64'(reg_q.size()), 64'd0);
        chk("dat_left", 64'(dat_q.size()), 64'd0);
    endtask

    initial begin
        rst = 1; lerr = 0; vld = 0; din = '0; last = 0; rrdy = 1; drdy = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_ready", 64'(rdy), 64'd1);
        chk("rst_reg_vld", 64'(rvld), 64'd0);
        chk("rst_dat_vld", 64'(dvld), 64'd0);
        chk("rst_drop", 64'(drop), 64'd0);
        @(posedge clk); #1;

        // 5-word register FIS
        frame(8'h34, 5, 1'b1, 1);
        drain();
        chk("drops_t1", 64'(drops_seen), 64'd0);

        // DATA FIS with sink toggling 1,0,1,0
        chk_rdy = 1;
        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    @(posedge clk); #1 drdy = ~drdy;
                end
                drdy = 1;
            end
            frame(8'h46, 9, 1'b1, 0);
        join
        chk_rdy = 0;
        drain();
        chk("t2_reg_vld", 64'(rvld), 64'd0);

        // Oversize register frame, then a legal one
        frame(8'h34, 9, 1'b0, 2);
        chk("t3_reg_vld", 64'(rvld), 64'd0);
        frame(8'h34, 3, 1'b1, 0);
        drain();
        chk("drops_t3", 64'(drops_seen), 64'd1);

        // Link error on word 3, then a DATA FIS must be recognised
        send({8'h34, 24'h000111}, 1'b0, 1'b0);
        send(32'h22222222, 1'b0, 1'b0);
        send(32'h33333333, 1'b0, 1'b1);
        chk("lerr_drop", 64'(drop), 64'd1);
        @(posedge clk); #1;
        chk("lerr_reg_vld", 64'(rvld), 64'd0);
        frame(8'h46, 2, 1'b1, 0);
        drain();
        chk("drops_t4", 64'(drops_seen), 64'd2);

        // Fill to full with the reader stalled
        rrdy = 0;
        for (int f = 0; f < 3; f++) frame(8'h34, 5, 1'b1, 0);
        send({8'h34, 24'h0000AA}, 1'b0, 1'b0);
        send(32'hBBBBBBBB, 1'b1, 1'b0);
        chk("full_drop", 64'(drop), 64'd1);
        chk("full_reg_vld", 64'(rvld), 64'd1);
        nread = 0; nlast = 0;
        #1 rrdy = 1;
        drain();
        chk("full_nread", 64'(nread), 64'd15);
        chk("full_nlast", 64'(nlast), 64'd3);
        chk("drops_t5", 64'(drops_seen), 64'd3);

        // Reset with a stalled DATA word
        drdy = 0;
        send({8'h46, 24'h00ABCD}, 1'b0, 1'b0);
        chk("pre_rst_dvld", 64'(dvld), 64'd1);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        chk("post_rst_dvld", 64'(dvld), 64'd0);
        chk("post_rst_rvld", 64'(rvld), 64'd0);
        chk("post_rst_ready", 64'(rdy), 64'd1);
        drdy = 1;
        frame(8'h34, 1, 1'b1, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
